hazard_ctrl: RTL

Pipeline hazard and stall controller for the 5-stage pipelined RISC-V core. It sits beside `control_unit` and sequences the pipeline registers. It detects load-use hazards between ID and EX, squashes wrong-path instructions on taken branches resolved in EX, and freezes the whole pipe while the data memory has not acknowledged an access. A sticky error halts the pipe if that acknowledge never arrives.

---
 rtl/pipeline_pkg.sv | 17 +
 rtl/sat_counter.sv | 30 +++
 rtl/hazard_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline types: hazard FSM states, register address width, opcodes
package pipeline_pkg;

   localparam int REG_ADDR_W = 5;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } hz_state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous active-high reset
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc && !(&count_q)) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall, branch squash and memory freeze/timeout sequencing
// Performance counters are built only when HAZARD_CTRL_PERF_EN is defined.
module hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_memread,
   input  logic                  ex_branch_taken,
   input  logic                  mem_req,
   input  logic                  mem_ready,
   output logic                  pc_write,
   output logic                  ifid_write,
   output logic                  idex_write,
   output logic                  exmem_write,
   output logic                  memwb_write,
   output logic                  ifid_flush,
   output logic                  idex_flush,
   output logic                  mem_timeout,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt,
   output logic [CNT_W-1:0]      freeze_cnt
);

   localparam int WCW = $clog2(MEM_TIMEOUT);
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

   hz_state_e      state_q, state_d;
   logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
   logic           mem_timeout_q, mem_timeout_d;
   logic           load_use, mem_busy, frozen, rules_active;

   assign load_use = ex_memread & (ex_rd != '0) &
                     ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
   assign mem_busy = mem_req & ~mem_ready;

   // Inside MEM_WAIT only the acknowledge matters; mem_req is ignored there.
   assign frozen       = ~reset & (((state_q == RUN) & mem_busy) |
                                   ((state_q == MEM_WAIT) & ~mem_ready));
   assign rules_active = ~reset & (((state_q == RUN) & ~mem_busy) |
                                   ((state_q == MEM_WAIT) & mem_ready));

   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = mem_timeout_q;
      pc_write      = 1'b0;
      ifid_write    = 1'b0;
      idex_write    = 1'b0;
      exmem_write   = 1'b0;
      memwb_write   = 1'b0;
      ifid_flush    = 1'b0;
      idex_flush    = 1'b0;
      if (reset) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (rules_active) begin
         state_d     = RUN;
         wait_cnt_d  = '0;
         pc_write    = 1'b1;
         ifid_write  = 1'b1;
         idex_write  = 1'b1;
         exmem_write = 1'b1;
         memwb_write = 1'b1;
         if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
         end
      end else if (frozen) begin
         if (state_q == RUN) begin
            state_d    = MEM_WAIT;
            wait_cnt_d = WCW'(1);
         end else if (wait_cnt_q == WAIT_LAST) begin
            state_d       = HALT;
            mem_timeout_d = 1'b1;
         end else begin
            wait_cnt_d = wait_cnt_q + WCW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= RUN;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_CTRL_PERF_EN
   logic stall_inc, flush_inc;

   assign flush_inc = rules_active & ex_branch_taken;
   assign stall_inc = rules_active & ~ex_branch_taken & load_use;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk  (clk),
      .reset(reset),
      .inc  (stall_inc),
      .count(stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk  (clk),
      .reset(reset),
      .inc  (flush_inc),
      .count(flush_cnt)
   );

   sat_counter #(.W(CNT_W)) u_freeze_cnt (
      .clk  (clk),
      .reset(reset),
      .inc  (frozen),
      .count(freeze_cnt)
   );
`else
   assign stall_cnt  = '0;
   assign flush_cnt  = '0;
   assign freeze_cnt = '0;
`endif

endmodule
